// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/DONE lifecycle, sequential or branch PC update,
// range-fault detection and a saturating retired-instruction counter.
module pc_sequencer #(
    parameter logic [15:0] START_ADDR = 16'd0,
    parameter int unsigned PROG_LEN   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stall,
    input  logic        halt,
    input  logic        branch_taken,
    input  logic [15:0] branch_targ,
    output logic [15:0] pc,
    output logic        running,
    output logic        done,
    output logic        fault,
    output logic [15:0] instr_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [16:0] PROG_LEN_W = 17'(PROG_LEN);

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic        running_q, running_d;
    // Widened by one bit so that 0xFFFF+1 lands out of range instead of wrapping to 0.
    logic [16:0] next_pc;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        fault_d = fault_q;
        next_pc = branch_taken ? {1'b0, branch_targ} : ({1'b0, pc_q} + 17'd1);

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = START_ADDR;
                    cnt_d   = 16'd0;
                    fault_d = 1'b0;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                    if (halt) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (next_pc >= PROG_LEN_W) begin
                        // Faulting PC is never exposed; pc keeps the last valid address.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                    end else begin
                        pc_d = next_pc[15:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= START_ADDR;
            cnt_q     <= 16'd0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            running_q <= running_d;
        end
    end

    assign pc        = pc_q;
    assign running   = running_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign instr_cnt = cnt_q;

endmodule
